// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan-chain controller: FSM encoding and byte width.
package scan_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_IN  = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_WAIT_OUT = 2'd3
    } state_t;

endpackage

// File: rtl/scan_byte_shifter.sv
// One-byte scan datapath: loads a byte, shifts it LSB-first into the chain while
// capturing scan_out into the vacated MSB, then holds the captured byte.
module scan_byte_shifter
    import scan_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_shift,
    input  logic              i_scan_out,
    output logic              o_scan_in,
    output logic [BYTE_W-1:0] o_data
);

    logic [BYTE_W-1:0] r_sh;

    // After BYTE_W shifts every outgoing bit has been replaced by a captured one,
    // captured bit k landing at position k.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {i_scan_out, r_sh[BYTE_W-1:1]};
        end
    end

    assign o_scan_in = i_shift & r_sh[0];
    assign o_data    = r_sh;

endmodule

// File: rtl/scan_chain_controller.sv
// Byte-streaming scan-chain controller: each frame exchanges CHAIN_BITS/8 bytes,
// one byte shifted in and one captured per 8-cycle SHIFT burst.
module scan_chain_controller
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_BITS = 144
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              core_hold_o,
    output logic              scan_enable_o,
    output logic              scan_in_o,
    input  logic              scan_out_i
);

    localparam int NBYTES = CHAIN_BITS / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_bit;
    logic [CNT_W-1:0] r_byte;
    logic             r_done;
    logic             w_load;
    logic             w_out_hs;
    logic             w_last_byte;

    assign w_load      = in_ready_o & in_valid_i;
    assign w_out_hs    = out_valid_o & out_ready_i;
    assign w_last_byte = (r_byte == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bit   <= '0;
            r_byte  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_out_hs & w_last_byte;
            if (r_state == ST_SHIFT) begin
                r_bit <= r_bit + 3'd1;
            end
            // The last handshake returns to IDLE, so the count restarts there.
            if (w_out_hs) begin
                r_byte <= w_last_byte ? '0 : r_byte + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        in_ready_o    = 1'b0;
        scan_enable_o = 1'b0;
        out_valid_o   = 1'b0;
        busy_o        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next = ST_WAIT_IN;
            end
            ST_WAIT_IN: begin
                in_ready_o = 1'b1;
                if (in_valid_i) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                scan_enable_o = 1'b1;
                if (r_bit == 3'd7) w_next = ST_WAIT_OUT;
            end
            ST_WAIT_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) w_next = w_last_byte ? ST_IDLE : ST_WAIT_IN;
            end
            default: begin
                busy_o = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    assign done_o      = r_done;
    assign core_hold_o = busy_o;

    scan_byte_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_data     (in_data_i),
        .i_shift    (scan_enable_o),
        .i_scan_out (scan_out_i),
        .o_scan_in  (scan_in_o),
        .o_data     (out_data_o)
    );

endmodule

// File: doc/scan_chain_controller.md
SCAN_CHAIN_CONTROLLER -- requirements
Module: scan_chain_controller

Interface
REQ-001 Parameter CHAIN_BITS, default 144, total scan-chain length in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  begins one full-chain frame when sampled high in IDLE.
REQ-005 in_data_i  input  8  byte to shift into the chain.
REQ-006 in_valid_i  input  1  in_data_i is valid.
REQ-007 in_ready_o  output  1  controller can accept a byte.
REQ-008 out_data_o  output  8  byte captured from the chain.
REQ-009 out_valid_o  output  1  out_data_o is valid.
REQ-010 out_ready_i  input  1  consumer accepts out_data_o.
REQ-011 busy_o  output  1  frame in progress.
REQ-012 done_o  output  1  one-cycle pulse when a frame completes.
REQ-013 core_hold_o  output  1  high while busy_o is high; integration uses it to freeze the scanned core.
REQ-014 scan_enable_o  output  1  drives the chain's scan_enable.
REQ-015 scan_in_o  output  1  drives the chain's first scan_in.
REQ-016 scan_out_i  input  1  last scan_out of the chain.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_IN, SHIFT and WAIT_OUT.
REQ-018 IDLE SHALL go to WAIT_IN on start_i; busy_o and core_hold_o are high in every state except IDLE.
REQ-019 start_i outside IDLE SHALL be ignored.
REQ-020 in_ready_o SHALL be high only in WAIT_IN; the handshake is in_valid_i & in_ready_o.
REQ-021 An accepted byte SHALL load the shift register and go to SHIFT.
REQ-022 SHIFT SHALL last exactly 8 cycles with scan_enable_o high.
REQ-023 scan_enable_o SHALL be low in all other states.
REQ-024 In shift cycle k (k = 0..7), scan_in_o SHALL equal in byte bit k (LSB first).
REQ-025 In shift cycle k, out bit k SHALL be scan_out_i as sampled at that cycle's clock edge.
REQ-026 Latency: byte accepted at edge T gives shift cycles T+1..T+8, and out_valid_o rises in cycle T+9 (WAIT_OUT).
REQ-027 out_data_o and out_valid_o SHALL hold stable in WAIT_OUT until out_valid_o & out_ready_i; no shifting occurs while stalled.
REQ-028 A byte counter SHALL count completed output handshakes, sized clog2(CHAIN_BITS/8+1).
REQ-029 On the handshake of byte CHAIN_BITS/8, the FSM SHALL go to IDLE with done_o high for that one following cycle; otherwise it goes to WAIT_IN.
REQ-030 in_valid_i in the same cycle as the WAIT_OUT handshake SHALL NOT be accepted, because in_ready_o is low in that cycle.
REQ-031 The 3-bit bit counter SHALL wrap 7->0 at the end of SHIFT.
REQ-032 The byte counter SHALL clear on entry to IDLE.

Reset
REQ-033 rst high at a clock edge, in any state including mid-SHIFT, SHALL force IDLE with both counters at 0.
REQ-034 rst SHALL force the following outputs low: scan_enable_o, scan_in_o, in_ready_o, out_valid_o, busy_o, done_o and core_hold_o.
REQ-035 rst SHALL set out_data_o to 0x00.
REQ-036 A frame aborted by reset SHALL NOT be resumed, and no done_o pulse SHALL be generated for it.

Structure
REQ-037 Package scan_ctrl_pkg SHALL hold the state encoding and the byte-width constant (8).
REQ-038 One sub-module, scan_byte_shifter, SHALL hold the 8-bit load/shift/capture datapath; the FSM and counters stay in the top.

Verification
REQ-039 Use a 16-bit chain model: scan_out = r[0]; on scan_enable, r <= {scan_in, r[15:1]}.
REQ-040 Scenario 1: CHAIN_BITS=16, model preloaded 0xBEEF, start, send 0x12 then 0x34 -> out bytes 0xEF then 0xBE, model ends at 0x3412, one done_o pulse.
REQ-041 Scenario 2: Single byte accepted at edge T -> scan_enable_o high exactly in cycles T+1..T+8, out_valid_o high at T+9.
REQ-042 Scenario 3: Hold out_ready_i low 20 cycles -> out_data_o stable, scan_enable_o low, model unchanged; releasing it completes the frame.
REQ-043 Scenario 4: Assert rst at shift cycle 4 -> next cycle all outputs low/zero, state IDLE, no done_o; a following full frame is correct.
REQ-044 Scenario 5: start_i pulsed during SHIFT and in_valid_i held high during WAIT_OUT -> neither is acted on early, byte count stays correct.
REQ-045 Scenario 6: CHAIN_BITS=144, model preloaded with a random value, 18 bytes with random gaps in in_valid_i/out_ready_i -> captured stream equals the preload LSB-first, and the model equals the sent bytes.
